// File: rtl/det_patgen_pkg.sv
// Shared types and March C- element tables for the deterministic SRAM pattern generator.
// DET_PATGEN_CHECKERBOARD_EN (see det_patgen_march) selects an address-dependent background.
package det_patgen_pkg;

  typedef enum logic [2:0] {E0, E1, E2, E3, E4, E5, DONE} march_elem_e;

  localparam int unsigned TOTAL_OPS_PER_ADDR = 10;

  // Index of the last op slot in an element (0 for single-op elements).
  function automatic logic elem_last_op(input march_elem_e e);
    return (e == E0 || e == E5) ? 1'b0 : 1'b1;
  endfunction

  // 1 = descending sweep.
  function automatic logic elem_dir(input march_elem_e e);
    return (e == E3 || e == E4);
  endfunction

  function automatic logic op_is_write(input march_elem_e e, input logic idx);
    case (e)
      E0:      return 1'b1;
      E1, E2,
      E3, E4:  return idx;
      default: return 1'b0;
    endcase
  endfunction

  // 0 = background word, 1 = its inverse.
  function automatic logic op_value(input march_elem_e e, input logic idx);
    case (e)
      E1, E3:  return idx;
      E2, E4:  return ~idx;
      default: return 1'b0;
    endcase
  endfunction

  function automatic march_elem_e next_elem(input march_elem_e e);
    case (e)
      E0:      return E1;
      E1:      return E2;
      E2:      return E3;
      E3:      return E4;
      E4:      return E5;
      default: return DONE;
    endcase
  endfunction

endpackage

// File: rtl/det_patgen_if.sv
// Pattern-generator interface: consumer (master) drives en, generator (slave) presents ops.
interface det_patgen_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = 4
);
  logic                  en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data;
  logic [DATA_WIDTH-1:0] check;
  logic [MASK_WIDTH-1:0] wmask;
  logic                  we;
  logic                  re;
  logic                  done;

  modport master (output en, input addr, data, check, wmask, we, re, done);
  modport slave  (input en, output addr, data, check, wmask, we, re, done);
endinterface

// File: rtl/det_patgen_addr_seq.sv
// Up/down address counter; dir is captured on load so at_end never depends on the load decision.
module det_patgen_addr_seq #(
  parameter int MAX_ADDR   = 16,
  parameter int ADDR_WIDTH = $clog2(MAX_ADDR)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  step,
  input  logic                  dir,
  input  logic                  load,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  at_end
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(MAX_ADDR - 1);

  logic dir_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr  <= '0;
      dir_q <= 1'b0;
    end else if (load) begin
      dir_q <= dir;
      addr  <= dir ? LAST : '0;
    end else if (step) begin
      addr <= dir_q ? addr - 1'b1 : addr + 1'b1;
    end
  end

  assign at_end = dir_q ? (addr == '0) : (addr == LAST);

endmodule

// File: rtl/det_patgen_march.sv
// March C- pattern generator driving the slave side of det_patgen_if.
// Optional: DET_PATGEN_CHECKERBOARD_EN makes the background 0101.. / 1010.. by addr[0].
module det_patgen_march
  import det_patgen_pkg::*;
#(
  parameter int MAX_ADDR   = 16,
  parameter int ADDR_WIDTH = $clog2(MAX_ADDR),
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  det_patgen_if.slave pg
);

  march_elem_e           elem_q, elem_n;
  logic                  opi_q, opi_n;
  logic                  step, load, dir_n, at_end;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] bg, val;
  logic                  active, wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      elem_q <= E0;
      opi_q  <= 1'b0;
    end else begin
      elem_q <= elem_n;
      opi_q  <= opi_n;
    end
  end

  always_comb begin
    elem_n = elem_q;
    opi_n  = opi_q;
    step   = 1'b0;
    load   = 1'b0;
    dir_n  = 1'b0;
    if (pg.en && elem_q != DONE) begin
      if (opi_q != elem_last_op(elem_q)) begin
        opi_n = opi_q + 1'b1;
      end else if (!at_end) begin
        opi_n = 1'b0;
        step  = 1'b1;
      end else begin
        // On completion addr is left untouched so it holds N-1.
        opi_n  = 1'b0;
        elem_n = next_elem(elem_q);
        if (elem_n != DONE) begin
          load  = 1'b1;
          dir_n = elem_dir(elem_n);
        end
      end
    end
  end

  det_patgen_addr_seq #(
    .MAX_ADDR   (MAX_ADDR),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_seq (
    .clk    (clk),
    .rst    (rst),
    .step   (step),
    .dir    (dir_n),
    .load   (load),
    .addr   (addr),
    .at_end (at_end)
  );

  always_comb begin
    bg = '0;
`ifdef DET_PATGEN_CHECKERBOARD_EN
    for (int unsigned i = 0; i < DATA_WIDTH; i++) bg[i] = ((i % 2) == 0);
    if (addr[0]) bg = ~bg;
`endif
    val = op_value(elem_q, opi_q) ? ~bg : bg;
  end

  // In DONE the decode falls back to a read of bg, matching the final E5 op.
  assign active   = (elem_q != DONE);
  assign wr       = op_is_write(elem_q, opi_q);
  assign pg.addr  = addr;
  assign pg.we    = active & wr;
  assign pg.re    = active & ~wr;
  assign pg.data  = pg.we ? val : '0;
  assign pg.check = wr ? '0 : val;
  assign pg.wmask = pg.we ? '1 : '0;
  assign pg.done  = ~active;

endmodule

// File: tb/tb_det_patgen_march.sv
// Scoreboard bench for det_patgen_march: N=4 and N=5 instances, DATA_WIDTH=8, MASK_WIDTH=1.
module tb_det_patgen_march;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic sel = 1'b0;

  always #5 clk = ~clk;

  det_patgen_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .MASK_WIDTH(1)) ifa ();
  det_patgen_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .MASK_WIDTH(1)) ifb ();

  assign ifa.en = en & ~sel;
  assign ifb.en = en & sel;

  det_patgen_march #(.MAX_ADDR(4), .DATA_WIDTH(8), .MASK_WIDTH(1)) dut_a (
    .clk (clk), .rst (rst), .pg (ifa.slave)
  );
  det_patgen_march #(.MAX_ADDR(5), .DATA_WIDTH(8), .MASK_WIDTH(1)) dut_b (
    .clk (clk), .rst (rst), .pg (ifb.slave)
  );

  int          o_addr;
  logic        o_we, o_re, o_wmask, o_done;
  logic [7:0]  o_data, o_check;

  always_comb begin
    if (sel) begin
      o_addr = int'(ifb.addr); o_we = ifb.we; o_re = ifb.re; o_wmask = ifb.wmask;
      o_done = ifb.done; o_data = ifb.data; o_check = ifb.check;
    end else begin
      o_addr = int'(ifa.addr); o_we = ifa.we; o_re = ifa.re; o_wmask = ifa.wmask;
      o_done = ifa.done; o_data = ifa.data; o_check = ifa.check;
    end
  end

  typedef struct {
    int         addr;
    bit         we;
    logic [7:0] val;
  } op_t;

  op_t q[$];
  int  checks = 0;
  int  errors = 0;

  function automatic logic [7:0] bg(input int a);
`ifdef DET_PATGEN_CHECKERBOARD_EN
    return (a % 2 == 0) ? 8'h55 : 8'hAA;
`else
    return 8'h00;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_elem(input int n, input bit down, input int nops,
                           input bit w0, input bit v0, input bit w1, input bit v1);
    op_t e;
    for (int k = 0; k < n; k++) begin
      e.addr = down ? n - 1 - k : k;
      e.we = w0; e.val = v0 ? ~bg(e.addr) : bg(e.addr);
      q.push_back(e);
      if (nops == 2) begin
        e.we = w1; e.val = v1 ? ~bg(e.addr) : bg(e.addr);
        q.push_back(e);
      end
    end
  endtask

  task automatic build(input int n);
    q.delete();
    push_elem(n, 0, 1, 1, 0, 0, 0);  // up   w0
    push_elem(n, 0, 2, 0, 0, 1, 1);  // up   r0,w1
    push_elem(n, 0, 2, 0, 1, 1, 0);  // up   r1,w0
    push_elem(n, 1, 2, 0, 0, 1, 1);  // down r0,w1
    push_elem(n, 1, 2, 0, 1, 1, 0);  // down r1,w0
    push_elem(n, 0, 1, 0, 0, 0, 0);  // up   r0
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_addr"},  o_addr, 0);
    check({tag, "_we"},    o_we, 1);
    check({tag, "_re"},    o_re, 0);
    check({tag, "_data"},  o_data, bg(0));
    check({tag, "_check"}, o_check, 0);
    check({tag, "_wmask"}, o_wmask, 1);
    check({tag, "_done"},  o_done, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Presents/consumes ops from the scoreboard; stop_after < 0 runs to completion.
  task automatic run_seq(input int n, input bit gaps, input int stop_after);
    op_t e;
    int  popped = 0;
    int  cyc = 0;
    build(n);
    while (q.size() > 0 && (stop_after < 0 || popped < stop_after)) begin
      @(negedge clk);
      e = q[0];
      check("op_addr",  o_addr, e.addr);
      check("op_we",    o_we, e.we);
      check("op_re",    o_re, !e.we);
      check("op_data",  o_data, e.we ? e.val : 8'h00);
      check("op_check", o_check, e.we ? 8'h00 : e.val);
      check("op_wmask", o_wmask, e.we);
      check("op_done",  o_done, 0);
      en = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      if (en) begin
        void'(q.pop_front());
        popped++;
      end
      cyc++;
      if (cyc > 2000) begin
        check("timeout", 1, 0);
        break;
      end
    end
    if (stop_after < 0) begin
      @(negedge clk);
      en = 1'b0;
      check("done_set",   o_done, 1);
      check("done_we",    o_we, 0);
      check("done_re",    o_re, 0);
      check("done_wmask", o_wmask, 0);
      check("done_addr",  o_addr, n - 1);
      check("done_data",  o_data, 8'h00);
      check("done_check", o_check, bg(n - 1));
      en = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("done_sticky",    o_done, 1);
      check("done_addr_hold", o_addr, n - 1);
      en = 1'b0;
    end
  endtask

  initial begin
    // Reset release, idle with en=0.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_reset_vals("idle");
    end

    // Continuous en on N=4.
    run_seq(4, 0, -1);

    // Random en gaps on N=4.
    do_reset();
    run_seq(4, 1, -1);

    // Async reset mid-E3, then full rerun.
    do_reset();
    run_seq(4, 0, 25);
    #2 rst = 1'b1;
    #1 check_reset_vals("async_rst");
    @(negedge clk);
    en = 1'b0;
    rst = 1'b0;
    run_seq(4, 0, -1);

    // Non-power-of-two sweep on N=5.
    sel = 1'b1;
    do_reset();
    check_reset_vals("n5_reset");
    run_seq(5, 1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
